// File: rtl/bsg_locking_arb_resp_router_if.sv
// Handshake bundle between the locking arbiter, the response router and the
// shared response channel. The router connects through the slave modport.
interface bsg_locking_arb_resp_router_if #(
  parameter int inputs_p          = 16,
  parameter int width_p           = 32,
  parameter int max_outstanding_p = 8
);
  localparam int owner_w_lp = (inputs_p > 1) ? $clog2(inputs_p) : 1;

  logic [inputs_p-1:0]   grants_i;
  logic                  last_i;
  logic                  arb_ready_o;
  logic                  unlock_o;
  logic                  resp_v_i;
  logic [width_p-1:0]    resp_data_i;
  logic                  resp_ready_o;
  logic [inputs_p-1:0]   resp_v_o;
  logic [width_p-1:0]    resp_data_o;
  logic [inputs_p-1:0]   resp_ready_i;
  logic [owner_w_lp-1:0] owner_id_o;
  logic                  busy_o;
  logic                  error_o;

  modport slave (
    input  grants_i, last_i, resp_v_i, resp_data_i, resp_ready_i,
    output arb_ready_o, unlock_o, resp_ready_o, resp_v_o, resp_data_o,
           owner_id_o, busy_o, error_o
  );

  modport master (
    output grants_i, last_i, resp_v_i, resp_data_i, resp_ready_i,
    input  arb_ready_o, unlock_o, resp_ready_o, resp_v_o, resp_data_o,
           owner_id_o, busy_o, error_o
  );
endinterface

// File: rtl/bsg_locking_arb_resp_router.sv
// Return-path router for the locking arbiter: tracks the lock owner and its
// outstanding beats, steers responses to it, and pulses unlock once drained.
//
//   state  | meaning
//   IDLE   | no lock held; next valid grant captures the owner
//   LOCKED | owner holds the lock, more beats may still be granted
//   DRAIN  | last beat granted; waiting for outstanding responses
//   UNLOCK | one-cycle unlock pulse to the arbiter
module bsg_locking_arb_resp_router #(
  parameter int inputs_p          = 16,
  parameter int width_p           = 32,
  parameter int max_outstanding_p = 8
) (
  input logic clk_i,
  input logic reset_n_i,
  bsg_locking_arb_resp_router_if.slave bus
);
  localparam int OW = (inputs_p > 1) ? $clog2(inputs_p) : 1;
  localparam int CW = $clog2(max_outstanding_p + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(max_outstanding_p);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    DRAIN  = 2'd2,
    UNLOCK = 2'd3
  } state_t;

  state_t          r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [OW-1:0]   r_owner, w_owner_n;
  logic            r_error;

  logic            w_grant_any;
  logic            w_onehot;
  logic [OW-1:0]   w_grant_idx;
  logic            w_grant_err;
  logic            w_grant_ok;
  logic            w_live;
  logic            w_resp_ready;
  logic            w_resp_fire;
  logic [inputs_p-1:0] w_owner_mask;

  assign w_grant_any = |bus.grants_i;
  assign w_onehot    = w_grant_any && ((bus.grants_i & (bus.grants_i - 1'b1)) == '0);

  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < inputs_p; i++) begin
      if (bus.grants_i[i]) w_grant_idx = i[OW-1:0];
    end
  end

  // Any offending grant is dropped entirely so cnt never wraps and owner holds.
  assign w_grant_err = w_grant_any &&
                       (!w_onehot ||
                        (r_state == LOCKED && !bus.grants_i[r_owner]) ||
                        r_state == DRAIN || r_state == UNLOCK ||
                        r_cnt == MAX_CNT);
  assign w_grant_ok  = w_grant_any && !w_grant_err;

  assign w_live       = (r_cnt != '0);
  assign w_resp_ready = bus.resp_ready_i[r_owner] & w_live;
  assign w_resp_fire  = bus.resp_v_i & w_resp_ready;
  assign w_owner_mask = {{(inputs_p-1){1'b0}}, 1'b1} << r_owner;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_owner_n = r_owner;
    case (r_state)
      IDLE: begin
        if (w_grant_ok) begin
          w_owner_n = w_grant_idx;
          w_cnt_n   = CW'(1);
          w_state_n = bus.last_i ? DRAIN : LOCKED;
        end
      end
      LOCKED: begin
        if (w_grant_ok && !w_resp_fire)      w_cnt_n = r_cnt + 1'b1;
        else if (!w_grant_ok && w_resp_fire) w_cnt_n = r_cnt - 1'b1;
        if (w_grant_ok && bus.last_i) w_state_n = DRAIN;
      end
      DRAIN: begin
        if (w_resp_fire) w_cnt_n = r_cnt - 1'b1;
        if (w_cnt_n == '0) w_state_n = UNLOCK;
      end
      UNLOCK: begin
        w_cnt_n   = '0;
        w_state_n = IDLE;
      end
      default: begin
        w_cnt_n   = '0;
        w_state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_owner <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_owner <= w_owner_n;
      r_error <= r_error | w_grant_err;
    end
  end

  assign bus.arb_ready_o  = (r_state == IDLE || r_state == LOCKED) && (r_cnt < MAX_CNT);
  assign bus.unlock_o     = (r_state == UNLOCK);
  assign bus.busy_o       = (r_state != IDLE);
  assign bus.owner_id_o   = r_owner;
  assign bus.error_o      = r_error;
  assign bus.resp_ready_o = w_resp_ready;
  assign bus.resp_v_o     = (bus.resp_v_i && w_live) ? w_owner_mask : '0;
  assign bus.resp_data_o  = bus.resp_data_i;
endmodule

// File: tb/tb_bsg_locking_arb_resp_router.sv
// Directed bench for the locking-arbiter response router.
module tb_bsg_locking_arb_resp_router;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  bsg_locking_arb_resp_router_if #(.inputs_p(16), .width_p(32), .max_outstanding_p(8)) bus_if ();

  bsg_locking_arb_resp_router #(.inputs_p(16), .width_p(32), .max_outstanding_p(8)) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .bus      (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] g, input logic l, input logic rv,
                       input logic [31:0] rd, input logic [15:0] rr);
    bus_if.grants_i     = g;
    bus_if.last_i       = l;
    bus_if.resp_v_i     = rv;
    bus_if.resp_data_i  = rd;
    bus_if.resp_ready_i = rr;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_unlock"}, 64'(bus_if.unlock_o), 64'd0);
    chk({tag, "_arb_ready"}, 64'(bus_if.arb_ready_o), 64'd1);
    chk({tag, "_resp_v"}, 64'(bus_if.resp_v_o), 64'd0);
    chk({tag, "_resp_ready"}, 64'(bus_if.resp_ready_o), 64'd0);
    chk({tag, "_busy"}, 64'(bus_if.busy_o), 64'd0);
    chk({tag, "_owner"}, 64'(bus_if.owner_id_o), 64'd0);
    chk({tag, "_error"}, 64'(bus_if.error_o), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(16'h0, 1'b0, 1'b0, 32'h0, 16'h0);
    #1;
    // Hold response valid high during reset: no owner count, so nothing steers.
    drive(16'h0, 1'b0, 1'b1, 32'h1234, 16'hFFFF);
    #1;
    chk_reset_outputs("rst");
    tick();
    tick();
    rst_n = 1'b1;
    drive(16'h0, 1'b0, 1'b0, 32'h0, 16'h0);
    tick();
    chk_reset_outputs("post_rst");

    // Single beat from requester 4
    drive(16'h0010, 1'b1, 1'b0, 32'h0, 16'h0);
    tick();
    chk("sb_busy", 64'(bus_if.busy_o), 64'd1);
    chk("sb_owner", 64'(bus_if.owner_id_o), 64'd4);
    chk("sb_cnt", 64'(dut.r_cnt), 64'd1);
    chk("sb_arb_ready_drain", 64'(bus_if.arb_ready_o), 64'd0);
    chk("sb_unlock_t1", 64'(bus_if.unlock_o), 64'd0);
    drive(16'h0, 1'b0, 1'b1, 32'hA5A5_0001, 16'h0010);
    #1;
    chk("sb_resp_v", 64'(bus_if.resp_v_o), 64'h0010);
    chk("sb_resp_ready", 64'(bus_if.resp_ready_o), 64'd1);
    chk("sb_resp_data", 64'(bus_if.resp_data_o), 64'hA5A5_0001);
    tick();
    drive(16'h0, 1'b0, 1'b0, 32'h0, 16'h0);
    chk("sb_unlock_t2", 64'(bus_if.unlock_o), 64'd1);
    chk("sb_arb_ready_unlock", 64'(bus_if.arb_ready_o), 64'd0);
    tick();
    chk("sb_unlock_t3", 64'(bus_if.unlock_o), 64'd0);
    chk("sb_busy_t3", 64'(bus_if.busy_o), 64'd0);
    chk("sb_arb_ready_t3", 64'(bus_if.arb_ready_o), 64'd1);
    chk("sb_owner_kept", 64'(bus_if.owner_id_o), 64'd4);

    // Burst of 4 from requester 9, last on the 4th beat
    for (int i = 0; i < 3; i++) begin
      drive(16'h0200, 1'b0, 1'b0, 32'h0, 16'h0);
      tick();
    end
    chk("burst_cnt3", 64'(dut.r_cnt), 64'd3);
    chk("burst_arb_ready", 64'(bus_if.arb_ready_o), 64'd1);
    chk("burst_owner", 64'(bus_if.owner_id_o), 64'd9);
    drive(16'h0200, 1'b1, 1'b0, 32'h0, 16'h0);
    tick();
    chk("burst_cnt4", 64'(dut.r_cnt), 64'd4);
    chk("burst_drain_ready", 64'(bus_if.arb_ready_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      drive(16'h0, 1'b0, 1'b1, 32'(32'hB000 + i), 16'hFFFF);
      #1;
      chk($sformatf("burst_resp_v%0d", i), 64'(bus_if.resp_v_o), 64'h0200);
      chk($sformatf("burst_unlock_pre%0d", i), 64'(bus_if.unlock_o), 64'd0);
      tick();
    end
    drive(16'h0, 1'b0, 1'b0, 32'h0, 16'h0);
    chk("burst_unlock", 64'(bus_if.unlock_o), 64'd1);
    chk("burst_cnt0", 64'(dut.r_cnt), 64'd0);
    tick();
    chk("burst_idle", 64'(bus_if.busy_o), 64'd0);

    // Credit limit with requester 1
    for (int i = 0; i < 7; i++) begin
      drive(16'h0002, 1'b0, 1'b0, 32'h0, 16'h0);
      tick();
    end
    chk("credit_ready7", 64'(bus_if.arb_ready_o), 64'd1);
    drive(16'h0002, 1'b0, 1'b0, 32'h0, 16'h0);
    tick();
    chk("credit_ready8", 64'(bus_if.arb_ready_o), 64'd0);
    chk("credit_cnt8", 64'(dut.r_cnt), 64'd8);
    drive(16'h0, 1'b0, 1'b1, 32'hC0DE, 16'h0002);
    tick();
    chk("credit_ready_back", 64'(bus_if.arb_ready_o), 64'd1);
    chk("credit_cnt7", 64'(dut.r_cnt), 64'd7);
    for (int i = 0; i < 4; i++) tick();
    chk("credit_cnt3", 64'(dut.r_cnt), 64'd3);

    // Grant and response together at cnt 3
    drive(16'h0002, 1'b0, 1'b1, 32'hD00D, 16'h0002);
    tick();
    chk("simul_cnt", 64'(dut.r_cnt), 64'd3);
    chk("simul_error", 64'(bus_if.error_o), 64'd0);
    chk("simul_busy", 64'(bus_if.busy_o), 64'd1);
    drive(16'h0002, 1'b1, 1'b0, 32'h0, 16'h0);
    tick();
    chk("credit_last_cnt", 64'(dut.r_cnt), 64'd4);
    drive(16'h0, 1'b0, 1'b1, 32'hE000, 16'h0002);
    for (int i = 0; i < 4; i++) tick();
    drive(16'h0, 1'b0, 1'b0, 32'h0, 16'h0);
    chk("credit_unlock", 64'(bus_if.unlock_o), 64'd1);
    tick();
    chk("credit_idle", 64'(bus_if.busy_o), 64'd0);

    // Non-one-hot grant in IDLE is flagged and ignored
    drive(16'h0003, 1'b0, 1'b0, 32'h0, 16'h0);
    tick();
    drive(16'h0, 1'b0, 1'b0, 32'h0, 16'h0);
    chk("multi_error", 64'(bus_if.error_o), 64'd1);
    chk("multi_cnt", 64'(dut.r_cnt), 64'd0);
    chk("multi_busy", 64'(bus_if.busy_o), 64'd0);
    chk("multi_owner", 64'(bus_if.owner_id_o), 64'd1);
    tick();
    chk("multi_sticky", 64'(bus_if.error_o), 64'd1);

    // Foreign grant while owner 2 holds the lock
    drive(16'h0004, 1'b0, 1'b0, 32'h0, 16'h0);
    tick();
    chk("foreign_owner_pre", 64'(bus_if.owner_id_o), 64'd2);
    drive(16'h0020, 1'b0, 1'b0, 32'h0, 16'h0);
    tick();
    chk("foreign_error", 64'(bus_if.error_o), 64'd1);
    chk("foreign_owner", 64'(bus_if.owner_id_o), 64'd2);
    chk("foreign_cnt", 64'(dut.r_cnt), 64'd1);
    drive(16'h0004, 1'b1, 1'b0, 32'h0, 16'h0);
    tick();
    drive(16'h0, 1'b0, 1'b0, 32'h0, 16'h0);
    chk("drain_cnt2", 64'(dut.r_cnt), 64'd2);
    chk("drain_busy", 64'(bus_if.busy_o), 64'd1);

    // Async reset in DRAIN with cnt 2, mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    chk("async_cnt", 64'(dut.r_cnt), 64'd0);
    tick();
    chk("async_unlock_a", 64'(bus_if.unlock_o), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("async_unlock_b", 64'(bus_if.unlock_o), 64'd0);
    chk("async_busy", 64'(bus_if.busy_o), 64'd0);
    drive(16'h0100, 1'b1, 1'b0, 32'h0, 16'h0);
    tick();
    chk("fresh_owner", 64'(bus_if.owner_id_o), 64'd8);
    chk("fresh_busy", 64'(bus_if.busy_o), 64'd1);
    chk("fresh_cnt", 64'(dut.r_cnt), 64'd1);
    drive(16'h0, 1'b0, 1'b1, 32'hF00D, 16'h0100);
    #1;
    chk("fresh_resp_v", 64'(bus_if.resp_v_o), 64'h0100);
    tick();
    drive(16'h0, 1'b0, 1'b0, 32'h0, 16'h0);
    chk("fresh_unlock", 64'(bus_if.unlock_o), 64'd1);
    chk("fresh_error", 64'(bus_if.error_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
